// File: rtl/cruzamento_pkg.sv
// Shared types and constants for the two-approach intersection controller.
// Holds the state enumeration, the lamp encodings, the default durations and the counter-load helper.
package cruzamento_pkg;

  typedef enum logic [2:0] {
    A_VERDE   = 3'd0,
    A_AMARELO = 3'd1,
    LIMPA_A   = 3'd2,
    B_VERDE   = 3'd3,
    B_AMARELO = 3'd4,
    LIMPA_B   = 3'd5,
    PED       = 3'd6
  } estado_t;

  localparam logic [2:0] VERDE    = 3'b001;
  localparam logic [2:0] AMARELO  = 3'b010;
  localparam logic [2:0] VERMELHO = 3'b100;

  localparam int T_VERDE_PAD   = 4;
  localparam int T_AMARELO_PAD = 2;
  localparam int T_LIMPA_PAD   = 1;
  localparam int T_PED_PAD     = 3;

  // A state lasting N cycles starts its down-counter at N-1 and leaves when it reads 0.
  function automatic logic [7:0] carga(input int duracao);
    return 8'(duracao - 1);
  endfunction

endpackage

// File: rtl/temporizador.sv
// 8-bit loadable down-counter with a zero flag; it saturates at zero instead of wrapping.
module temporizador #(
  parameter logic [7:0] VAL_RESET = 8'd0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       carrega,
  input  logic [7:0] valor,
  output logic       zero
);

  logic [7:0] contagem;

  always_ff @(posedge clk) begin
    if (rst)
      contagem <= VAL_RESET;
    else if (carrega)
      contagem <= valor;
    else if (contagem != 8'd0)
      contagem <= contagem - 8'd1;
  end

  assign zero = (contagem == 8'd0);

endmodule

// File: rtl/cruzamento_ctrl.sv
// Traffic-light controller for two approaches plus a pedestrian walk phase.
// All outputs are decoded from registered state only.
module cruzamento_ctrl
  import cruzamento_pkg::*;
#(
  parameter int T_VERDE   = T_VERDE_PAD,
  parameter int T_AMARELO = T_AMARELO_PAD,
  parameter int T_LIMPA   = T_LIMPA_PAD,
  parameter int T_PED     = T_PED_PAD
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       bt,
  input  logic       sa,
  input  logic       sb,
  output logic [2:0] A,
  output logic [2:0] B,
  output logic       P,
  output logic       ped_pend
);

  estado_t    estado;
  estado_t    proximo;
  logic       ultimo;
  logic       fim;
  logic       carrega;
  logic [7:0] valor_carga;

  temporizador #(
    .VAL_RESET(carga(T_VERDE))
  ) u_temporizador (
    .clk     (clk),
    .rst     (rst),
    .carrega (carrega),
    .valor   (valor_carga),
    .zero    (fim)
  );

  always_ff @(posedge clk) begin
    if (rst)
      estado <= A_VERDE;
    else
      estado <= proximo;
  end

  // Green rests at counter 0 until the opposite approach or a pedestrian asks for the road.
  always_comb begin
    proximo = estado;
    unique case (estado)
      A_VERDE:   if (fim && (sb || ped_pend)) proximo = A_AMARELO;
      A_AMARELO: if (fim) proximo = LIMPA_A;
      LIMPA_A:   if (fim) proximo = ped_pend ? PED : B_VERDE;
      B_VERDE:   if (fim && (sa || ped_pend)) proximo = B_AMARELO;
      B_AMARELO: if (fim) proximo = LIMPA_B;
      LIMPA_B:   if (fim) proximo = ped_pend ? PED : A_VERDE;
      PED:       if (fim) proximo = ultimo ? A_VERDE : B_VERDE;
      default:   proximo = A_VERDE;
    endcase
  end

  // Every state change reloads the counter with the duration of the state being entered.
  always_comb begin
    carrega = (proximo != estado);
    unique case (proximo)
      A_VERDE, B_VERDE:     valor_carga = carga(T_VERDE);
      A_AMARELO, B_AMARELO: valor_carga = carga(T_AMARELO);
      LIMPA_A, LIMPA_B:     valor_carga = carga(T_LIMPA);
      PED:                  valor_carga = carga(T_PED);
      default:              valor_carga = carga(T_VERDE);
    endcase
  end

  // A button press in the very cycle that enters PED is absorbed by that walk phase.
  always_ff @(posedge clk) begin
    if (rst) begin
      ped_pend <= 1'b0;
      ultimo   <= 1'b1;
    end else begin
      if (proximo == PED && estado != PED)
        ped_pend <= 1'b0;
      else if (bt)
        ped_pend <= 1'b1;
      if (proximo == LIMPA_A && estado != LIMPA_A)
        ultimo <= 1'b0;
      else if (proximo == LIMPA_B && estado != LIMPA_B)
        ultimo <= 1'b1;
    end
  end

  always_comb begin
    A = VERMELHO;
    B = VERMELHO;
    P = 1'b0;
    unique case (estado)
      A_VERDE:   A = VERDE;
      A_AMARELO: A = AMARELO;
      B_VERDE:   B = VERDE;
      B_AMARELO: B = AMARELO;
      PED:       P = 1'b1;
      default:   ;
    endcase
  end

endmodule

// File: doc/cruzamento_ctrl.md
CRUZAMENTO_CTRL -- requirements
Module: cruzamento_ctrl

Interface
REQ-001 Parameter T_VERDE, default 4: minimum green cycles per approach, legal range 1..255.
REQ-002 Parameter T_AMARELO, default 2: yellow cycles, legal range 1..255.
REQ-003 Parameter T_LIMPA, default 1: all-red clearance cycles, legal range 1..255.
REQ-004 Parameter T_PED, default 3: pedestrian walk cycles, legal range 1..255.
REQ-005 clk  in  1  single system clock; all state updates on its rising edge.
REQ-006 rst  in  1  reset, synchronous and active-high.
REQ-007 bt  in  1  pedestrian button, level-sampled every cycle.
REQ-008 sa  in  1  vehicle demand, approach A.
REQ-009 sb  in  1  vehicle demand, approach B.
REQ-010 A  out  3  light A, one-hot: 3'b001 green, 3'b010 yellow, 3'b100 red.
REQ-011 B  out  3  light B, same encoding as A.
REQ-012 P  out  1  pedestrian walk, 1 = walk.
REQ-013 ped_pend  out  1  latched pedestrian request not yet served.

Function
REQ-014 The FSM SHALL have exactly 7 states: A_VERDE, A_AMARELO, LIMPA_A, B_VERDE, B_AMARELO, LIMPA_B, PED.
REQ-015 Outputs SHALL be Moore, decoded from state only: A_VERDE A=001 B=100; A_AMARELO A=010 B=100; B_VERDE A=100 B=001; B_AMARELO A=100 B=010; LIMPA_x and PED A=B=100; P=1 only in PED.
REQ-016 Each state SHALL last exactly its parameter count of cycles: a down-counter is loaded with N-1 on entry and the state exits when the counter reads 0.
REQ-017 A_VERDE with counter 0 SHALL go to A_AMARELO if (sb | ped_pend); otherwise it SHALL rest in A_VERDE with the counter held at 0. B_VERDE is symmetric, using (sa | ped_pend).
REQ-018 x_AMARELO SHALL go to LIMPA_x after T_AMARELO cycles.
REQ-019 LIMPA_A SHALL go to PED if ped_pend=1, else to B_VERDE; LIMPA_B SHALL go to PED if ped_pend=1, else to A_VERDE.
REQ-020 PED SHALL exit after T_PED cycles to the green of the approach not served last. A 1-bit register ultimo (0=A, 1=B) is written on entry to each LIMPA_x.
REQ-021 ped_pend SHALL be set in any cycle with bt=1, except the cycle of the transition into PED.
REQ-022 ped_pend SHALL clear on the transition into PED; a bt=1 in that same cycle SHALL be discarded.
REQ-023 bt=1 while in PED SHALL set ped_pend, and that request is served after the next clearance.
REQ-024 sa/sb SHALL NOT be latched; demand is evaluated only in the green-exit cycle.
REQ-025 Yellow SHALL never be skipped, and green SHALL never be shortened below T_VERDE, regardless of inputs.
REQ-026 The counter SHALL be 8-bit unsigned and SHALL never wrap: it stops at 0.

Reset
REQ-027 With rst=1 at a clock edge, the next state SHALL be A_VERDE with the counter at T_VERDE-1, ped_pend=0 and ultimo=1, giving A=001, B=100, P=0.
REQ-028 rst SHALL have priority over bt and over every transition, including mid-yellow and mid-PED.

Structure
REQ-029 Package cruzamento_pkg SHALL hold the state enumeration, the light constants VERDE=3'b001, AMARELO=3'b010 and VERMELHO=3'b100, and the default durations.
REQ-030 Sub-module temporizador (8-bit loadable down-counter with a zero flag) SHALL be used once.
REQ-031 The block SHALL contain no combinational path from inputs to outputs.

Verification
REQ-032 Idle: rst in cycle 0, then sa=sb=bt=0 for 30 cycles -> A=001, B=100, P=0 throughout.
REQ-033 Vehicle swap: sb=1 from reset release, taken as cycle 0 -> A green cycles 0-3, yellow 4-5, all-red 6, B green from 7.
REQ-034 Pedestrian: bt=1 in cycle 1 only, sa=sb=0 -> ped_pend=1 from cycle 2; A green 0-3, yellow 4-5, LIMPA_A 6, PED cycles 7-9 (P=1, A=B=100), ped_pend=0 from 7, B green from 10.
REQ-035 Button during walk: bt=1 in cycle 8 of the REQ-034 run, sa=1 -> ped_pend=1 from 9; B green 10-13, yellow 14-15, LIMPA_B 16, PED 17-19, A green from 20.
REQ-036 Reset mid-operation: rst=1 during B_AMARELO with ped_pend=1 -> next cycle A=001, B=100, P=0, ped_pend=0.
REQ-037 Continuous demand: sa=sb=1, bt=0 -> 14-cycle period, A green 4 of every 14 cycles, A and B never simultaneously non-red.
